// File: rtl/abs_mav_acc_if.sv
// abs_mav_acc_if: sample-in / MAV-out bundle
// for the ear-EEG rectify-and-average block.
interface abs_mav_acc_if #(
  parameter int DATA_W = 13,
  parameter int CH_W   = 2
);

  logic              in_valid;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-2:0] out_mav;
  logic              out_sat;

  modport master (
    output in_valid,
    output in_ch,
    output in_data,
    input  out_valid,
    input  out_ch,
    input  out_mav,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_ch,
    input  in_data,
    output out_valid,
    output out_ch,
    output out_mav,
    output out_sat
  );

endinterface

// File: rtl/abs_mav_acc.sv
// abs_mav_acc: per-channel |x| window mean
// with saturation flag, two-stage pipeline.
module abs_mav_acc #(
  parameter int DATA_W   = 13,
  parameter int CH_NUM   = 4,
  parameter int LOG2_WIN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  abs_mav_acc_if.slave  bus
);

  localparam int CH_W  =
    (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int A_W   = DATA_W - 1;
  localparam int ACC_W = A_W + LOG2_WIN;

  localparam logic [CH_W:0] CH_LIM =
    (CH_W+1)'(CH_NUM);
  localparam logic [DATA_W-1:0] MIN_CODE =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef logic [CH_W-1:0]     ch_t;
  typedef logic [A_W-1:0]      a_t;
  typedef logic [ACC_W-1:0]    acc_t;
  typedef logic [LOG2_WIN-1:0] cnt_t;

  typedef struct packed {
    logic valid;
    ch_t  ch;
    a_t   a1;
    logic sat;
  } s1_t;

  s1_t  s1;

  logic accept;
  logic is_neg;
  logic is_min;
  a_t   neg_lo;
  a_t   a1_d;
  logic sat_d;

  acc_t acc [CH_NUM];
  cnt_t cnt [CH_NUM];
  logic sat [CH_NUM];

  acc_t cur_acc;
  cnt_t cur_cnt;
  logic cur_sat;
  acc_t sum;
  logic last;
  logic close;

  logic  ov_q;
  ch_t   och_q;
  a_t    omav_q;
  logic  osat_q;

  assign accept = bus.in_valid &&
    ({1'b0, bus.in_ch} < CH_LIM);

  assign is_neg = bus.in_data[DATA_W-1];
  assign is_min = (bus.in_data == MIN_CODE);

  // Low bits of the negation are exact for
  // every negative code except the minimum.
  assign neg_lo =
    ~bus.in_data[A_W-1:0] + a_t'(1);

  // Rectify; the lone unrepresentable code
  // clamps to full scale and flags it.
  always_comb begin
    a1_d  = bus.in_data[A_W-1:0];
    sat_d = 1'b0;
    unique case (1'b1)
      is_min: begin
        a1_d  = '1;
        sat_d = 1'b1;
      end
      (is_neg && !is_min): begin
        a1_d = neg_lo;
      end
      default: begin
        a1_d = bus.in_data[A_W-1:0];
      end
    endcase
  end

  // Stage 1 register: |x|, channel, flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1.valid <= accept && !clear;
      if (accept) begin
        s1.ch  <= bus.in_ch;
        s1.a1  <= a1_d;
        s1.sat <= sat_d;
      end
    end
  end

  // Read the addressed channel's state; the
  // update lands the same edge, so a
  // back-to-back sample sees fresh values.
  always_comb begin
    cur_acc = '0;
    cur_cnt = '0;
    cur_sat = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (s1.ch == ch_t'(c)) begin
        cur_acc = acc[c];
        cur_cnt = cnt[c];
        cur_sat = sat[c];
      end
    end
  end

  assign sum   = cur_acc + acc_t'(s1.a1);
  assign last  = (cur_cnt == '1);
  assign close = s1.valid && last && !clear;

  // Stage 2: per-channel accumulate, reset
  // the channel when its window closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
        sat[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (clear) begin
          acc[c] <= '0;
          cnt[c] <= '0;
          sat[c] <= 1'b0;
        end else if (s1.valid &&
                     s1.ch == ch_t'(c)) begin
          if (last) begin
            acc[c] <= '0;
            cnt[c] <= '0;
            sat[c] <= 1'b0;
          end else begin
            acc[c] <= sum;
            cnt[c] <= cur_cnt + cnt_t'(1);
            sat[c] <= cur_sat | s1.sat;
          end
        end
      end
    end
  end

  // Result register: pulse on close, hold
  // the last result otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      och_q  <= '0;
      omav_q <= '0;
      osat_q <= 1'b0;
    end else begin
      ov_q <= close;
      if (close) begin
        och_q  <= s1.ch;
        omav_q <= sum[ACC_W-1:LOG2_WIN];
        osat_q <= cur_sat | s1.sat;
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_ch    = och_q;
  assign bus.out_mav   = omav_q;
  assign bus.out_sat   = osat_q;

endmodule
